exe_div_lane: RTL and testbench
===============================

# exe_div_lane

Iterative integer divide execute lane that consumes the operand packet produced by the RegRead→Execute pipeline register and returns a writeback result several cycles later. It implements the RISC-V DIV/DIVU/REM/REMU family with a radix-2 restoring algorithm, one quotient bit per cycle. It raises `busy_o` to the issue/RegRead logic while an iteration is in flight. It honours the pipeline flush in the same way as the surrounding stage registers.

## Interface
- `DATA_WIDTH`, 64: operand/result width.
- `TAG_WIDTH`, 7: physical destination tag width.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `flush_i` in 1: synchronous pipeline flush; discards all in-flight work.
- `exeValid_i` in 1: an operation is presented this cycle.
- `exeOp_i` in 2: 0=DIV, 1=DIVU, 2=REM, 3=REMU.
- `exeWord_i` in 1: 32-bit W-form op. Used only when `DIV_WORD_OP_EN` is defined.
- `src1Data_i` in DATA_WIDTH: dividend.
- `src2Data_i` in DATA_WIDTH: divisor.
- `destTag_i` in TAG_WIDTH: destination physical register.
- `busy_o` out 1: lane cannot accept this cycle. Combinational from state; high only in CALC.
- `wbValid_o` out 1: result valid, one-cycle pulse, registered.
- `wbTag_o` out TAG_WIDTH: tag of the result.
- `wbData_o` out DATA_WIDTH: quotient or remainder.

## Operation
- States: IDLE, CALC, DONE. Reset and flush both force IDLE.
- Accept condition: `exeValid_i & ~busy_o & ~flush_i`, sampled at a clock edge, in state IDLE or DONE.
- `exeValid_i` while `busy_o` is a protocol violation. The input is dropped and state is unchanged.
- On accept, the lane latches op, tag and operands, then:
  - Divisor zero: go to DONE. Quotient = all ones; remainder = dividend.
  - Signed op with dividend = most-negative and divisor = −1: go to DONE. Quotient = dividend; remainder = 0.
  - Otherwise: latch |dividend| and |divisor| (signed ops) or the raw values (unsigned). Clear the partial remainder, set counter = 0, go to CALC.
- Each edge in CALC:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem using a DATA_WIDTH+1 bit subtractor.
  - If the result is non-negative, commit it to rem and set the quotient LSB.
  - Increment the counter.
- After the iteration with counter = N−1 (N = DATA_WIDTH, or 32 for word ops), go to DONE.
- Sign fix-up on the CALC→DONE edge, signed ops only:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- In DONE: `wbValid_o`=1, `wbTag_o`/`wbData_o` hold the selected result. Next edge goes to IDLE, or to CALC/DONE if a new op is accepted.
- Outputs outside DONE: `wbValid_o`=0. `wbData_o` and `wbTag_o` hold their last values.

## Timing
- Reset values: state IDLE, `busy_o`=0, `wbValid_o`=0, `wbTag_o`=0, `wbData_o`=0, counter 0.
- Let edge 0 be the accept edge.
  - Normal op: CALC after edge 0 through edge N−1. DONE (`wbValid_o`=1) in the cycle after edge N. Latency N+1 cycles; `busy_o` is high for N cycles.
  - Special case (divide by zero or overflow): `wbValid_o`=1 in the cycle after edge 0. Latency 1 cycle; `busy_o` never rises.
- Accepting in DONE is legal. The completing result still pulses that cycle, so back-to-back throughput is one op per N+1 cycles.
- Flush:
  - Takes effect at the edge where it is sampled.
  - Flush in CALC or DONE: state goes to IDLE, `wbValid_o`=0 the next cycle, no writeback is issued.
  - Flush and `exeValid_i` in the same cycle: flush wins and the op is dropped.
  - Reset has identical priority.
- Word ops use N=32, so latency is 33 cycles.

## Configuration
- `DIV_WORD_OP_EN` defined: `exeWord_i` is honoured for word ops.
  - Operands are taken from bits [31:0]: sign-extended for DIV/REM, zero-extended for DIVU/REMU.
  - Special-case checks use 32-bit values (most-negative = 0x8000_0000).
  - The iteration runs 32 steps.
  - The result is sign-extended from bit 31 to DATA_WIDTH.
- Undefined: `exeWord_i` is ignored and all ops are full DATA_WIDTH. The port remains present.

## Test plan
- DIVU 100/7, tag 5:
  - `busy_o` high for 64 cycles.
  - `wbValid_o` pulse 65 cycles after accept.
  - `wbData_o`=14, `wbTag_o`=5.
  - REMU of the same operands gives 2.
- DIV −7/2 gives −3; REM −7/2 gives −1 (0xFFFF_FFFF_FFFF_FFFF).
- DIV 42/0:
  - `wbData_o`=0xFFFF_FFFF_FFFF_FFFF one cycle after accept, `busy_o` never high.
  - REM 42/0 gives 42.
- DIV 0x8000_0000_0000_0000 / −1 gives 0x8000_0000_0000_0000 at latency 1; REM gives 0.
- Flush:
  - Flush asserted 10 cycles into CALC: `busy_o` low the next cycle, no `wbValid_o` ever for that op.
  - `exeValid_i`+`flush_i` together: the op is not accepted.
- Back-to-back:
  - Second op presented during DONE is accepted; the first result pulses that cycle, the second 65 cycles later.
  - `exeValid_i` presented while busy is ignored.
  - With `DIV_WORD_OP_EN`, DIVW 0x0000_0001_FFFF_FFF9 / 2 gives 0xFFFF_FFFF_FFFF_FFFD at 33-cycle latency.

Source files
------------

// File: rtl/exe_div_lane.sv
// Radix-2 restoring divide lane for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_WORD_OP_EN enables 32-bit W-form ops selected by exeWord_i.
module exe_div_lane #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  exeValid_i,
  input  logic [1:0]            exeOp_i,
  input  logic                  exeWord_i,
  input  logic [DATA_WIDTH-1:0] src1Data_i,
  input  logic [DATA_WIDTH-1:0] src2Data_i,
  input  logic [TAG_WIDTH-1:0]  destTag_i,
  output logic                  busy_o,
  output logic                  wbValid_o,
  output logic [TAG_WIDTH-1:0]  wbTag_o,
  output logic [DATA_WIDTH-1:0] wbData_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(31);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic [DATA_WIDTH-1:0] sext32(input logic [DATA_WIDTH-1:0] v);
    return {{(DATA_WIDTH-32){v[31]}}, v[31:0]};
  endfunction

  state_t                  state, state_n;
  logic                    op_rem, word_r, neg_q, neg_r;
  logic [TAG_WIDTH-1:0]    tag_r;
  logic [DATA_WIDTH-1:0]   rem_r, quo_r, dvsr_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    wb_valid;
  logic [TAG_WIDTH-1:0]    wb_tag;
  logic [DATA_WIDTH-1:0]   wb_data;

  logic                    word_in, signed_op, accept;
  logic [DATA_WIDTH-1:0]   a_ext, b_ext, min_neg, a_mag, b_mag;
  logic                    a_neg, b_neg, div_zero, overflow, special;
  logic [DATA_WIDTH-1:0]   spec_pick, spec_res;

`ifdef DIV_WORD_OP_EN
  assign word_in = exeWord_i;
`else
  logic unused_word;
  assign unused_word = exeWord_i;
  assign word_in     = 1'b0;
`endif

  assign busy_o    = (state == CALC);
  assign accept    = exeValid_i & ~busy_o & ~flush_i;
  assign signed_op = ~exeOp_i[0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    a_ext   = src1Data_i;
    b_ext   = src2Data_i;
    min_neg = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    if (word_in) begin
      a_ext   = signed_op ? sext32(src1Data_i) : {{(DATA_WIDTH-32){1'b0}}, src1Data_i[31:0]};
      b_ext   = signed_op ? sext32(src2Data_i) : {{(DATA_WIDTH-32){1'b0}}, src2Data_i[31:0]};
      min_neg = {{(DATA_WIDTH-31){1'b1}}, 31'b0};
    end
  end

  assign a_neg     = signed_op & a_ext[DATA_WIDTH-1];
  assign b_neg     = signed_op & b_ext[DATA_WIDTH-1];
  assign a_mag     = a_neg ? -a_ext : a_ext;
  assign b_mag     = b_neg ? -b_ext : b_ext;
  assign div_zero  = (b_ext == '0);
  assign overflow  = signed_op & (a_ext == min_neg) & (&b_ext);
  assign special   = div_zero | overflow;
  // Divide-by-zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
  assign spec_pick = exeOp_i[1] ? (div_zero ? a_ext : '0) : (div_zero ? '1 : a_ext);
  assign spec_res  = word_in ? sext32(spec_pick) : spec_pick;

  // One restoring step: shift {rem, quo} left, trial-subtract with a borrow bit.
  logic [DATA_WIDTH:0]   trial;
  logic                  fits, last_iter;
  logic [DATA_WIDTH-1:0] rem_step, quo_step, q_fix, r_fix, calc_pick, calc_res;

  assign trial     = {rem_r, quo_r[DATA_WIDTH-1]} - {1'b0, dvsr_r};
  assign fits      = ~trial[DATA_WIDTH];
  assign rem_step  = fits ? trial[DATA_WIDTH-1:0] : {rem_r[DATA_WIDTH-2:0], quo_r[DATA_WIDTH-1]};
  assign quo_step  = {quo_r[DATA_WIDTH-2:0], fits};
  assign last_iter = (cnt_r == (word_r ? LAST_WORD : LAST_FULL));
  assign q_fix     = neg_q ? -quo_step : quo_step;
  assign r_fix     = neg_r ? -rem_step : rem_step;
  assign calc_pick = op_rem ? r_fix : q_fix;
  assign calc_res  = word_r ? sext32(calc_pick) : calc_pick;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: state_n = accept ? (special ? DONE : CALC) : IDLE;
      CALC:       if (last_iter) state_n = DONE;
      default:    state_n = IDLE;
    endcase
    if (flush_i) state_n = IDLE;
  end

  // NOTE: the iteration datapath is not reset; it is always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt_r    <= '0;
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_data  <= '0;
    end else begin
      state    <= state_n;
      wb_valid <= (state_n == DONE);
      if (accept) begin
        op_rem <= exeOp_i[1];
        word_r <= word_in;
        tag_r  <= destTag_i;
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        if (special) begin
          wb_data <= spec_res;
          wb_tag  <= destTag_i;
        end else begin
          rem_r  <= '0;
          quo_r  <= word_in ? {a_mag[31:0], {(DATA_WIDTH-32){1'b0}}} : a_mag;
          dvsr_r <= b_mag;
          cnt_r  <= '0;
        end
      end else if (state == CALC && !flush_i) begin
        rem_r <= rem_step;
        quo_r <= quo_step;
        cnt_r <= cnt_r + CNT_W'(1);
        if (last_iter) begin
          wb_data <= calc_res;
          wb_tag  <= tag_r;
        end
      end
    end
  end

  assign wbValid_o = wb_valid;
  assign wbTag_o   = wb_tag;
  assign wbData_o  = wb_data;

endmodule

// File: tb/tb_exe_div_lane.sv
// Directed self-checking bench for exe_div_lane: arithmetic, special cases, flush, back-to-back.
module tb_exe_div_lane;

  localparam int W  = 64;
  localparam int TW = 7;
  localparam int NV = 17;

  logic          clk;
  logic          reset;
  logic          flush_i;
  logic          exeValid_i;
  logic [1:0]    exeOp_i;
  logic          exeWord_i;
  logic [W-1:0]  src1Data_i;
  logic [W-1:0]  src2Data_i;
  logic [TW-1:0] destTag_i;
  logic          busy_o;
  logic          wbValid_o;
  logic [TW-1:0] wbTag_o;
  logic [W-1:0]  wbData_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] op;
    logic       word;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int         lat;
  } vec_t;

  vec_t tbl [NV];

  exe_div_lane #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush_i),
    .exeValid_i (exeValid_i),
    .exeOp_i    (exeOp_i),
    .exeWord_i  (exeWord_i),
    .src1Data_i (src1Data_i),
    .src2Data_i (src2Data_i),
    .destTag_i  (destTag_i),
    .busy_o     (busy_o),
    .wbValid_o  (wbValid_o),
    .wbTag_o    (wbTag_o),
    .wbData_o   (wbData_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [1:0] op, input logic word, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TW-1:0] tag);
    exeValid_i = 1'b1;
    exeOp_i    = op;
    exeWord_i  = word;
    src1Data_i = a;
    src2Data_i = b;
    destTag_i  = tag;
  endtask

  // Presents one op, waits (bounded) for the writeback pulse, then steps one more cycle.
  task automatic do_op(input logic [1:0] op, input logic word, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tag,
                       output int lat, output int busy_n, output logic [W-1:0] data,
                       output logic [TW-1:0] tg, output bit seen);
    present(op, word, a, b, tag);
    tick();
    exeValid_i = 1'b0;
    lat = 1; busy_n = 0; seen = 1'b0; data = '0; tg = '0;
    while (!seen && lat < 200) begin
      if (wbValid_o) begin
        seen = 1'b1;
        data = wbData_o;
        tg   = wbTag_o;
      end else begin
        if (busy_o) busy_n++;
        tick();
        lat++;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    n_vec++; if (busy_o !== 1'b0)    begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
    n_vec++; if (wbValid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", wbValid_o); end
    n_vec++; if (wbTag_o !== '0)     begin n_err++; $display("FAIL reset_tag: got %0d exp 0", wbTag_o); end
    n_vec++; if (wbData_o !== '0)    begin n_err++; $display("FAIL reset_data: got %h exp 0", wbData_o); end
    // Reset in the middle of an iteration abandons it.
    present(2'd1, 1'b0, 64'd100, 64'd7, 7'd4);
    tick();
    exeValid_i = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (busy_o !== 1'b0)    begin n_err++; $display("FAIL midreset_busy: got %b exp 0", busy_o); end
    n_vec++; if (wbValid_o !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b exp 0", wbValid_o); end
    n_vec++; if (wbData_o !== '0)    begin n_err++; $display("FAIL midreset_data: got %h exp 0", wbData_o); end
  endtask

  task automatic test_arith();
    int lat, busy_n, exp_busy;
    logic [W-1:0] data;
    logic [TW-1:0] tg;
    bit seen;
    tbl[0]  = '{2'd1, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    tbl[1]  = '{2'd3, 1'b0, 64'd100, 64'd7, 64'd2, 65};
    tbl[2]  = '{2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    tbl[3]  = '{2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    tbl[4]  = '{2'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    tbl[5]  = '{2'd2, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65};
    tbl[6]  = '{2'd0, 1'b0, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    tbl[7]  = '{2'd2, 1'b0, 64'd42, 64'd0, 64'd42, 1};
    tbl[8]  = '{2'd1, 1'b0, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    tbl[9]  = '{2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    tbl[10] = '{2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    tbl[11] = '{2'd1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65};
    tbl[12] = '{2'd3, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 65};
    tbl[13] = '{2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hC000_0000_0000_0000, 65};
`ifdef DIV_WORD_OP_EN
    tbl[14] = '{2'd0, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
    tbl[15] = '{2'd2, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    tbl[16] = '{2'd1, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'h0000_0000_7FFF_FFFC, 33};
`else
    tbl[14] = '{2'd0, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'h0000_0000_FFFF_FFFC, 65};
    tbl[15] = '{2'd2, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'd1, 65};
    tbl[16] = '{2'd1, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'h0000_0000_FFFF_FFFC, 65};
`endif
    for (int i = 0; i < NV; i++) begin
      do_op(tbl[i].op, tbl[i].word, tbl[i].a, tbl[i].b, TW'(i + 5), lat, busy_n, data, tg, seen);
      exp_busy = (tbl[i].lat == 1) ? 0 : tbl[i].lat - 1;
      n_vec++;
      if (!seen || data !== tbl[i].exp) begin
        n_err++; $display("FAIL arith[%0d]_data: got %h exp %h (seen=%0d)", i, data, tbl[i].exp, seen);
      end
      n_vec++;
      if (lat != tbl[i].lat) begin
        n_err++; $display("FAIL arith[%0d]_latency: got %0d exp %0d", i, lat, tbl[i].lat);
      end
      n_vec++;
      if (busy_n != exp_busy) begin
        n_err++; $display("FAIL arith[%0d]_busy_cycles: got %0d exp %0d", i, busy_n, exp_busy);
      end
      n_vec++;
      if (tg !== TW'(i + 5)) begin
        n_err++; $display("FAIL arith[%0d]_tag: got %0d exp %0d", i, tg, i + 5);
      end
      n_vec++;
      if (wbValid_o !== 1'b0) begin
        n_err++; $display("FAIL arith[%0d]_pulse_width: valid still %b exp 0", i, wbValid_o);
      end
    end
  endtask

  task automatic test_flush();
    bit stray;
    present(2'd0, 1'b0, 64'd1000, 64'd3, 7'd9);
    tick();
    exeValid_i = 1'b0;
    repeat (10) tick();
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL flush_precond_busy: got %b exp 1", busy_o); end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b exp 0", busy_o); end
    stray = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (wbValid_o || busy_o) stray = 1'b1;
      tick();
    end
    n_vec++; if (stray) begin n_err++; $display("FAIL flush_no_wb: got stray activity exp none"); end
    // Flush together with a special-case op: it would otherwise pulse next cycle.
    present(2'd0, 1'b0, 64'd42, 64'd0, 7'd11);
    flush_i = 1'b1;
    tick();
    exeValid_i = 1'b0;
    flush_i    = 1'b0;
    n_vec++; if (wbValid_o !== 1'b0) begin n_err++; $display("FAIL flush_same_special: valid %b exp 0", wbValid_o); end
    // Flush together with a normal op: it must not start iterating.
    present(2'd1, 1'b0, 64'd100, 64'd7, 7'd12);
    flush_i = 1'b1;
    tick();
    exeValid_i = 1'b0;
    flush_i    = 1'b0;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_same_normal: busy %b exp 0", busy_o); end
    stray = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (wbValid_o || busy_o) stray = 1'b1;
      tick();
    end
    n_vec++; if (stray) begin n_err++; $display("FAIL flush_same_no_wb: got stray activity exp none"); end
  endtask

  task automatic test_back_to_back();
    int lat, pulses;
    present(2'd1, 1'b0, 64'd100, 64'd7, 7'd1);
    tick();
    exeValid_i = 1'b0;
    lat = 1;
    while (!wbValid_o && lat < 200) begin
      tick();
      lat++;
    end
    n_vec++; if (lat != 65)        begin n_err++; $display("FAIL b2b_first_latency: got %0d exp 65", lat); end
    n_vec++; if (wbData_o !== 64'd14) begin n_err++; $display("FAIL b2b_first_data: got %h exp e", wbData_o); end
    n_vec++; if (wbTag_o !== 7'd1) begin n_err++; $display("FAIL b2b_first_tag: got %0d exp 1", wbTag_o); end
    // Second op is presented in the DONE cycle of the first.
    present(2'd1, 1'b0, 64'd1000, 64'd10, 7'd2);
    tick();
    exeValid_i = 1'b0;
    n_vec++; if (busy_o !== 1'b1)    begin n_err++; $display("FAIL b2b_second_busy: got %b exp 1", busy_o); end
    n_vec++; if (wbValid_o !== 1'b0) begin n_err++; $display("FAIL b2b_second_valid: got %b exp 0", wbValid_o); end
    lat = 1;
    while (!wbValid_o && lat < 200) begin
      if (lat == 10) present(2'd1, 1'b0, 64'd9, 64'd0, 7'd3);
      tick();
      exeValid_i = 1'b0;
      lat++;
    end
    n_vec++; if (lat != 65)           begin n_err++; $display("FAIL b2b_second_latency: got %0d exp 65", lat); end
    n_vec++; if (wbData_o !== 64'd100) begin n_err++; $display("FAIL b2b_second_data: got %h exp 64", wbData_o); end
    n_vec++; if (wbTag_o !== 7'd2)    begin n_err++; $display("FAIL b2b_second_tag: got %0d exp 2", wbTag_o); end
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (wbValid_o) pulses++;
    end
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL b2b_busy_drop: got %0d extra pulses exp 0", pulses); end
  endtask

  initial begin
    reset      = 1'b1;
    flush_i    = 1'b0;
    exeValid_i = 1'b0;
    exeOp_i    = 2'd0;
    exeWord_i  = 1'b0;
    src1Data_i = '0;
    src2Data_i = '0;
    destTag_i  = '0;
    test_reset();
    test_arith();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
